dlychain_loader: RTL
====================

# dlychain_loader

Serial loader for the DMB daisy-chained programmable delay chips: cable delay and CFEB clock delay. It sits directly downstream of the serial-flash configuration block. It takes the restored CABLEDLY / FEB clock-delay values plus a load strobe, shifts a 16-bit frame into the chain with a divided serial clock, and latches it. It also checks the bits shifted back out of the chain against the previously loaded frame.

## Interface
Parameters:
- CLKDIV, 4, CLKCMS cycles per DLYCLK half-period (legal 2..15)
- NBITS, 16, frame length in bits (fixed at 16 for this chain)

Ports (clock and reset first):
- CLKCMS  input  1  system clock; only clock in the block
- RST_B  input  1  reset, asynchronous, active-low
- START  input  1  load request; internal rising-edge detect
- CABLEDLY  input  8  cable delay value, frame bits [7:0]
- FEBCLKDLY  input  5  FEB clock delay value, frame bits [12:8]
- DLYSO  input  1  serial output returned from the end of the chain
- DLYCLK  output  1  serial clock to the chain
- DLYDATA  output  1  serial data to the chain, MSB first
- DLYEN_B  output  1  chain enable, active-low
- DLYLOAD  output  1  latch strobe, active-high
- BUSY  output  1  high from frame capture through end of GAP
- DONE  output  1  one-cycle pulse at end of each load
- MISMATCH  output  1  sticky readback-error flag
- LOADCNT  output  8  count of completed loads, wraps 255→0

## Operation
- Frame = {3'b000, FEBCLKDLY, CABLEDLY}. It is captured into the shift register and into `cur_frame` on the capture cycle.
- State machine states: IDLE, SETUP, SHIFT, LATCH, GAP.
- IDLE: DLYCLK=0, DLYDATA=0, DLYEN_B=1, DLYLOAD=0, BUSY=0.
  - A START rising edge captures the frame, sets BUSY=1 and moves to SETUP.
- SETUP: lasts CLKDIV cycles.
  - DLYEN_B=0, DLYDATA=frame[15], DLYCLK=0.
- SHIFT: 16 bits; each bit is a low phase then a high phase, CLKDIV cycles each.
  - Last cycle of the low phase: sample DLYSO into the readback register.
  - End of the high phase: shift left and present the next bit.
  - After bit 0's high phase, go to LATCH.
- LATCH: lasts CLKDIV cycles.
  - DLYCLK=0, DLYEN_B=1, DLYLOAD=1, DLYDATA=0.
- GAP: lasts CLKDIV cycles, all chain outputs idle.
  - Last cycle: DONE=1 and LOADCNT+1.
  - Readback compare: if `prev_valid` and readback≠`prev_frame`, set MISMATCH.
  - Then `prev_frame`←`cur_frame` and `prev_valid`←1.
  - If `pending`, clear it and re-enter capture (→SETUP, BUSY stays 1); otherwise go to IDLE.
- A START rising edge while BUSY=1 (any state, including the DONE cycle) sets `pending`. Multiple edges collapse to one. The re-run uses the input values present at re-capture.
- MISMATCH clears only on reset.
- The first load after reset never flags, because `prev_valid`=0.
- Reset (async, any time, mid-frame included) forces the following within the same cycle, with no partial latch pulse:
  - DLYCLK=0, DLYDATA=0, DLYEN_B=1, DLYLOAD=0
  - BUSY=0, DONE=0, MISMATCH=0, LOADCNT=0
  - `pending`=0, `prev_valid`=0, state IDLE

## Timing
- START is sampled on the CLKCMS edge E and edge-detected against its value at E-1.
- Capture happens at E+1: BUSY, DLYEN_B=0 and DLYDATA=MSB are visible after E+1.
- Load length = (1 + 32 + 1 + 1)·CLKDIV = 35·CLKDIV cycles from capture to the last GAP cycle inclusive. That is 140 cycles at CLKDIV=4.
- DONE is high for exactly one cycle, coincident with the last GAP cycle. BUSY falls the cycle after DONE unless `pending` is set.
- DLYDATA is stable for the entire DLYCLK high phase (setup ≥ CLKDIV cycles).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package holds:
  - state enum (IDLE, SETUP, SHIFT, LATCH, GAP)
  - `NBITS` constant
  - frame-field offsets: `CBL_LSB`=0, `FEB_LSB`=8
- Sub-module: `dlyclk_div`, the phase counter that produces a terminal-count pulse every CLKDIV cycles, enabled outside IDLE.
- The bit counter (4-bit plus phase bit), shift register, readback register, `prev_frame` and LOADCNT stay in the top-level block.

## Test plan
- Reset release, CABLEDLY=8'hA5, FEBCLKDLY=5'h13, START pulse -> 16 DLYCLK rising edges with DLYDATA sequence 16'h13A5 MSB first; DLYLOAD high 4 cycles; DONE 140 cycles after capture; LOADCNT=1; MISMATCH=0.
- Second load 16'h0011 with chain model returning the old frame -> DLYSO stream 16'h13A5, MISMATCH stays 0; then a load with DLYSO stuck at 0 -> MISMATCH=1 after that load's DONE and stays 1.
- Three START edges during one load -> exactly one extra load, BUSY continuous, LOADCNT +2, second frame uses inputs at re-capture.
- START rising edge in the DONE cycle -> immediate re-run without BUSY dropping.
- RST_B low at bit 7 of SHIFT -> same-cycle idle outputs, no DLYLOAD pulse, LOADCNT=0, and the next load does not check readback.
- CLKDIV=2, 256 loads -> LOADCNT wraps to 0, each load is 70 cycles.

Source files
------------

// File: rtl/dlychain_loader_pkg.sv
// Shared definitions for the DMB delay-chain serial loader.
package dlychain_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        LATCH,
        GAP
    } state_e;

    localparam int unsigned NBITS   = 16;
    localparam int unsigned CBL_LSB = 0;
    localparam int unsigned FEB_LSB = 8;

endpackage

// File: rtl/dlychain_loader_dlyclk_div.sv
// Phase counter: terminal-count pulse every CLKDIV cycles while enabled.
module dlyclk_div #(
    parameter int unsigned CLKDIV = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    output logic tc_o,
    output logic pre_tc_o
);

    localparam int unsigned CW = 4;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc_o     = en_i && (cnt_q == CW'(CLKDIV - 1));
    // One cycle ahead of tc_o, so callers can register a strobe for the last cycle.
    assign pre_tc_o = en_i && (cnt_q == CW'(CLKDIV - 2));

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || tc_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dlychain_loader.sv
// Serial loader for the daisy-chained cable / CFEB clock delay chips,
// with readback compare of the frame shifted back out of the chain.
module dlychain_loader #(
    parameter int unsigned CLKDIV = 4,
    parameter int unsigned NBITS  = dlychain_loader_pkg::NBITS
) (
    input  logic       CLKCMS,
    input  logic       RST_B,
    input  logic       START,
    input  logic [7:0] CABLEDLY,
    input  logic [4:0] FEBCLKDLY,
    input  logic       DLYSO,
    output logic       DLYCLK,
    output logic       DLYDATA,
    output logic       DLYEN_B,
    output logic       DLYLOAD,
    output logic       BUSY,
    output logic       DONE,
    output logic       MISMATCH,
    output logic [7:0] LOADCNT
);

    import dlychain_loader_pkg::*;

    localparam int unsigned BCW = $clog2(NBITS);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(NBITS - 1);

    state_e           state_q, state_d;
    logic             phase_q, phase_d;
    logic [BCW-1:0]   bitcnt_q, bitcnt_d;
    logic [NBITS-1:0] sr_q, sr_d;
    logic [NBITS-1:0] rb_q, rb_d;
    logic [NBITS-1:0] cur_q, cur_d;
    logic [NBITS-1:0] prev_q, prev_d;
    logic             prev_valid_q, prev_valid_d;
    logic             pending_q, pending_d;
    logic             mismatch_q, mismatch_d;
    logic [7:0]       loadcnt_q, loadcnt_d;
    logic             start_q;
    logic             rise_q;
    logic             dlyclk_q, dlyclk_d;
    logic             dlydata_q, dlydata_d;
    logic             dlyen_b_q, dlyen_b_d;
    logic             dlyload_q, dlyload_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             rise_now;
    logic             capture;
    logic             tc;
    logic             pre_tc;
    logic [NBITS-1:0] frame;

    dlyclk_div #(
        .CLKDIV (CLKDIV)
    ) u_div (
        .clk_i    (CLKCMS),
        .rst_n_i  (RST_B),
        .en_i     (state_q != IDLE),
        .tc_o     (tc),
        .pre_tc_o (pre_tc)
    );

    always_comb begin
        frame = '0;
        frame[CBL_LSB +: 8] = CABLEDLY;
        frame[FEB_LSB +: 5] = FEBCLKDLY;
    end

    // Idle loads start one cycle after the edge is seen (rise_q); while busy the
    // edge is acted on immediately so a rise in the DONE cycle chains without a BUSY gap.
    always_comb begin
        rise_now     = START & ~start_q;
        capture      = 1'b0;
        state_d      = state_q;
        phase_d      = phase_q;
        bitcnt_d     = bitcnt_q;
        sr_d         = sr_q;
        rb_d         = rb_q;
        cur_d        = cur_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        pending_d    = pending_q;
        mismatch_d   = mismatch_q;
        loadcnt_d    = loadcnt_q;

        if ((state_q != IDLE) && rise_now) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (rise_q) begin
                    capture = 1'b1;
                end
            end
            SETUP: begin
                if (tc) begin
                    state_d  = SHIFT;
                    phase_d  = 1'b0;
                    bitcnt_d = '0;
                end
            end
            SHIFT: begin
                if (tc) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        rb_d    = {rb_q[NBITS-2:0], DLYSO};
                    end else begin
                        phase_d = 1'b0;
                        sr_d    = {sr_q[NBITS-2:0], 1'b0};
                        if (bitcnt_q == BIT_LAST) begin
                            state_d = LATCH;
                        end else begin
                            bitcnt_d = bitcnt_q + BCW'(1);
                        end
                    end
                end
            end
            LATCH: begin
                if (tc) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (tc) begin
                    loadcnt_d    = loadcnt_q + 8'd1;
                    if (prev_valid_q && (rb_q != prev_q)) begin
                        mismatch_d = 1'b1;
                    end
                    prev_d       = cur_q;
                    prev_valid_d = 1'b1;
                    pending_d    = 1'b0;
                    if (pending_q || rise_now) begin
                        capture = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            state_d = SETUP;
            sr_d    = frame;
            cur_d   = frame;
        end

        dlyclk_d  = (state_d == SHIFT) && phase_d;
        dlydata_d = ((state_d == SETUP) || (state_d == SHIFT)) && sr_d[NBITS-1];
        dlyen_b_d = !((state_d == SETUP) || (state_d == SHIFT));
        dlyload_d = (state_d == LATCH);
        busy_d    = (state_d != IDLE);
        done_d    = (state_q == GAP) && pre_tc;
    end

    always_ff @(posedge CLKCMS or negedge RST_B) begin
        if (!RST_B) begin
            state_q      <= IDLE;
            phase_q      <= 1'b0;
            bitcnt_q     <= '0;
            sr_q         <= '0;
            rb_q         <= '0;
            cur_q        <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            pending_q    <= 1'b0;
            mismatch_q   <= 1'b0;
            loadcnt_q    <= '0;
            start_q      <= 1'b0;
            rise_q       <= 1'b0;
            dlyclk_q     <= 1'b0;
            dlydata_q    <= 1'b0;
            dlyen_b_q    <= 1'b1;
            dlyload_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            bitcnt_q     <= bitcnt_d;
            sr_q         <= sr_d;
            rb_q         <= rb_d;
            cur_q        <= cur_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            pending_q    <= pending_d;
            mismatch_q   <= mismatch_d;
            loadcnt_q    <= loadcnt_d;
            start_q      <= START;
            rise_q       <= rise_now;
            dlyclk_q     <= dlyclk_d;
            dlydata_q    <= dlydata_d;
            dlyen_b_q    <= dlyen_b_d;
            dlyload_q    <= dlyload_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign DLYCLK   = dlyclk_q;
    assign DLYDATA  = dlydata_q;
    assign DLYEN_B  = dlyen_b_q;
    assign DLYLOAD  = dlyload_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign MISMATCH = mismatch_q;
    assign LOADCNT  = loadcnt_q;

endmodule
